// File: rtl/block_uart_streamer_pkg.sv
// Shared types and elaboration-time helpers for the block UART streamer.
// The divider and byte-count clamp live here so the top and sub-module agree on them.
package uart_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_e;

    function automatic int div_calc(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // A request of zero means a whole block; anything larger than the block is trimmed to it.
    function automatic int clamp_nbytes(input int nb, input int req);
        return ((req == 0) || (req > nb)) ? nb : req;
    endfunction

endpackage

// File: rtl/block_uart_streamer_baud_tick_gen.sv
// Free-running bit-period divider: tick marks the last clock of each DIV-cycle bit period.
// clr holds the count at zero so the first period after a start is always full length.
module baud_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/block_uart_streamer.sv
// Sends a latched wide word as back-to-back 8N1 (or 8N2) UART frames on a registered tx line.
// done/busy are decoded from the final stop-bit tick so they coincide with the last stop cycle.
module block_uart_streamer
    import uart_stream_pkg::*;
#(
    parameter int CLK_HZ    = 12000000,
    parameter int BAUD      = 9600,
    parameter int DATA_W    = 512,
    parameter int MSB_FIRST = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [DATA_W-1:0]                data_in,
    input  logic [$clog2(DATA_W/8+1)-1:0]    nbytes,
    output logic                             busy,
    output logic                             done,
    output logic                             byte_stb,
    output logic                             tx
);

    localparam int DIV   = div_calc(CLK_HZ, BAUD);
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = $clog2(NB + 1);

    state_e            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [2:0]        bitCnt_q;
    logic              stopCnt_q;
    logic [CNT_W-1:0]  byteCnt_q;
    logic [CNT_W-1:0]  nbytes_q;
    logic [CNT_W-1:0]  nbytes_d;
    logic              tx_q;
    logic              byteStb_q;

    logic       tick;
    logic       accept;
    logic       lastStop;
    logic       lastByte;
    logic       finalTick;
    logic [7:0] curByte;

    baud_tick_gen #(
        .DIV (DIV)
    ) uBaud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == IDLE),
        .tick  (tick)
    );

    // The done cycle is still STOP_BIT, so a start there is ignored without extra gating.
    assign accept    = start && (state_q == IDLE);
    assign nbytes_d  = CNT_W'(clamp_nbytes(NB, int'(nbytes)));
    assign curByte   = (MSB_FIRST != 0) ? shift_q[DATA_W-1 -: 8] : shift_q[7:0];
    assign lastStop  = (stopCnt_q == 1'(STOP_BITS - 1));
    assign lastByte  = (byteCnt_q == nbytes_q);
    assign finalTick = (state_q == STOP_BIT) && tick && lastStop && lastByte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bitCnt_q  <= '0;
            stopCnt_q <= 1'b0;
            byteCnt_q <= '0;
            nbytes_q  <= '0;
            tx_q      <= 1'b1;
            byteStb_q <= 1'b0;
        end else begin
            byteStb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= START_BIT;
                        shift_q   <= data_in;
                        nbytes_q  <= nbytes_d;
                        byteCnt_q <= '0;
                        bitCnt_q  <= '0;
                        tx_q      <= 1'b0;
                        byteStb_q <= 1'b1;
                    end
                end
                START_BIT: begin
                    if (tick) begin
                        state_q  <= DATA_BITS;
                        bitCnt_q <= '0;
                        tx_q     <= curByte[0];
                    end
                end
                DATA_BITS: begin
                    if (tick) begin
                        if (bitCnt_q == 3'd7) begin
                            state_q   <= STOP_BIT;
                            stopCnt_q <= 1'b0;
                            tx_q      <= 1'b1;
                            byteCnt_q <= byteCnt_q + CNT_W'(1);
                            shift_q   <= (MSB_FIRST != 0) ? (shift_q << 8) : (shift_q >> 8);
                        end else begin
                            bitCnt_q <= bitCnt_q + 3'd1;
                            tx_q     <= curByte[bitCnt_q + 3'd1];
                        end
                    end
                end
                STOP_BIT: begin
                    if (tick) begin
                        if (!lastStop) begin
                            stopCnt_q <= 1'b1;
                        end else if (lastByte) begin
                            state_q <= IDLE;
                        end else begin
                            state_q   <= START_BIT;
                            bitCnt_q  <= '0;
                            tx_q      <= 1'b0;
                            byteStb_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx       = tx_q;
    assign byte_stb = byteStb_q;
    assign done     = finalTick;
    assign busy     = (state_q != IDLE) && !finalTick;

endmodule

// File: tb/tb_block_uart_streamer.sv
// Bench for block_uart_streamer: three instances (LSB-first, MSB-first, two stop bits) at DIV=10.
// A line decoder per instance pops expected bytes from a shared scoreboard queue.
module tb_block_uart_streamer;

    typedef struct packed {
        logic [1:0] inst;
        logic [7:0] b;
    } exp_t;

    typedef struct {
        int          inst;
        logic [31:0] data;
        logic [2:0]  nb;
        int          expLen;
        bit          msb;
        int          frame;
    } vector_t;

    logic        clk;
    logic        rst_n;
    logic        startA [3];
    logic        busyA  [3];
    logic        doneA  [3];
    logic        stbA   [3];
    logic        txA    [3];
    logic [31:0] dataIn;
    logic [2:0]  nbytes;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t expQ[$];
    int   stbLog[$];
    int   doneLog[$];

    block_uart_streamer #(.CLK_HZ(1000), .BAUD(100), .DATA_W(32), .MSB_FIRST(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(startA[0]), .data_in(dataIn), .nbytes(nbytes),
        .busy(busyA[0]), .done(doneA[0]), .byte_stb(stbA[0]), .tx(txA[0]));

    block_uart_streamer #(.CLK_HZ(1000), .BAUD(100), .DATA_W(32), .MSB_FIRST(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(startA[1]), .data_in(dataIn), .nbytes(nbytes),
        .busy(busyA[1]), .done(doneA[1]), .byte_stb(stbA[1]), .tx(txA[1]));

    block_uart_streamer #(.CLK_HZ(1000), .BAUD(100), .DATA_W(32), .MSB_FIRST(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(startA[2]), .data_in(dataIn), .nbytes(nbytes),
        .busy(busyA[2]), .done(doneA[2]), .byte_stb(stbA[2]), .tx(txA[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe and done cycles are logged at the falling edge for later timing checks.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (stbA[k] === 1'b1) stbLog.push_back(cyc);
            if (doneA[k] === 1'b1) doneLog.push_back(cyc);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] modelByte(input logic [31:0] d, input int i, input bit msb);
        return msb ? d[31 - 8*i -: 8] : d[8*i +: 8];
    endfunction

    task automatic waitCycles(input int n, inout bit aborted);
        for (int c = 0; c < n && !aborted; c++) begin
            @(negedge clk);
            if (rst_n !== 1'b1) aborted = 1'b1;
        end
    endtask

    // Samples each bit mid-period; a reset during a frame discards it silently.
    task automatic monitorLine(input int k, input int stopBits);
        logic [7:0] rx;
        bit         aborted;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && txA[k] === 1'b0) begin
                aborted = 1'b0;
                rx      = '0;
                waitCycles(4, aborted);
                for (int i = 0; i < 8; i++) begin
                    waitCycles(10, aborted);
                    rx[i] = txA[k];
                end
                for (int s = 0; s < stopBits; s++) begin
                    waitCycles(10, aborted);
                    if (!aborted) checkOutput($sformatf("stop bit u%0d", k), 32'(txA[k]), 32'd1);
                end
                if (!aborted) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected byte u%0d: got 0x%0h, expected none", k, rx);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput($sformatf("byte source u%0d", k), 32'(k), 32'(e.inst));
                        checkOutput($sformatf("line byte u%0d", k), 32'(rx), 32'(e.b));
                    end
                end
            end
        end
    endtask

    initial monitorLine(0, 1);
    initial monitorLine(1, 1);
    initial monitorLine(2, 2);

    task automatic applyStimulus(input int k, input logic [31:0] data, input logic [2:0] nb,
                                 input int expLen, input bit msb, output int tAcc);
        @(negedge clk);
        dataIn    = data;
        nbytes    = nb;
        startA[k] = 1'b1;
        tAcc      = cyc;
        stbLog.delete();
        doneLog.delete();
        for (int i = 0; i < expLen; i++) expQ.push_back('{inst: 2'(k), b: modelByte(data, i, msb)});
        @(negedge clk);
        startA[k] = 1'b0;
        checkOutput("busy after accept", 32'(busyA[k]), 32'd1);
        checkOutput("tx start bit after accept", 32'(txA[k]), 32'd0);
    endtask

    task automatic waitDone(input int k, input int tAcc, input int expLat, output int tDone);
        tDone = -1;
        for (int n = 0; n < expLat + 100; n++) begin
            @(negedge clk);
            if (doneA[k] === 1'b1) begin
                tDone = cyc;
                break;
            end
        end
        if (tDone < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done timeout u%0d: got no done, expected at +%0d", k, expLat);
        end else begin
            checkOutput("done latency", 32'(tDone - tAcc), 32'(expLat));
            checkOutput("busy low in done cycle", 32'(busyA[k]), 32'd0);
        end
    endtask

    task automatic checkStrobes(input int tAcc, input int expLen, input int frame);
        checkOutput("byte_stb count", 32'(stbLog.size()), 32'(expLen));
        for (int i = 0; i < expLen && i < stbLog.size(); i++)
            checkOutput($sformatf("byte_stb %0d offset", i), 32'(stbLog[i] - tAcc), 32'(1 + i*frame));
    endtask

    task automatic checkAfterDone(input int k);
        @(negedge clk);
        checkOutput("done one cycle", 32'(doneA[k]), 32'd0);
        checkOutput("busy idle after done", 32'(busyA[k]), 32'd0);
        checkOutput("tx idle after done", 32'(txA[k]), 32'd1);
    endtask

    vector_t vecs [6];
    int      tAcc;
    int      tDone;
    int      bad;

    initial begin
        vecs[0] = '{0, 32'h44332211, 3'd0, 4, 1'b0, 100};
        vecs[1] = '{1, 32'hA55A0F0F, 3'd2, 2, 1'b1, 100};
        vecs[2] = '{1, 32'hA55A0F0F, 3'd7, 4, 1'b1, 100};
        vecs[3] = '{0, 32'hDEADBEEF, 3'd1, 1, 1'b0, 100};
        vecs[4] = '{1, 32'h12345678, 3'd4, 4, 1'b1, 100};
        vecs[5] = '{2, 32'h000000C3, 3'd3, 3, 1'b0, 110};

        rst_n  = 1'b0;
        dataIn = '0;
        nbytes = '0;
        for (int k = 0; k < 3; k++) startA[k] = 1'b0;

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("reset tx u%0d", k), 32'(txA[k]), 32'd1);
            checkOutput($sformatf("reset busy u%0d", k), 32'(busyA[k]), 32'd0);
            checkOutput($sformatf("reset done u%0d", k), 32'(doneA[k]), 32'd0);
            checkOutput($sformatf("reset byte_stb u%0d", k), 32'(stbA[k]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("idle tx u%0d", k), 32'(txA[k]), 32'd1);
            checkOutput($sformatf("idle busy u%0d", k), 32'(busyA[k]), 32'd0);
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].inst, vecs[i].data, vecs[i].nb, vecs[i].expLen, vecs[i].msb, tAcc);
            waitDone(vecs[i].inst, tAcc, vecs[i].expLen * vecs[i].frame, tDone);
            checkStrobes(tAcc, vecs[i].expLen, vecs[i].frame);
            checkAfterDone(vecs[i].inst);
            checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
            repeat (3) @(negedge clk);
        end

        // Starts while busy (mid-block and in the done cycle) must be ignored.
        applyStimulus(0, 32'hCAFEF00D, 3'd0, 4, 1'b0, tAcc);
        while (cyc < tAcc + 50) @(negedge clk);
        startA[0] = 1'b1;
        dataIn    = 32'hFFFFFFFF;
        nbytes    = 3'd1;
        @(negedge clk);
        startA[0] = 1'b0;
        checkOutput("busy held after ignored start", 32'(busyA[0]), 32'd1);
        waitDone(0, tAcc, 400, tDone);
        checkStrobes(tAcc, 4, 100);
        startA[0] = 1'b1;
        dataIn    = 32'h5A5A5A96;
        nbytes    = 3'd1;
        @(negedge clk);
        checkOutput("idle gap tx", 32'(txA[0]), 32'd1);
        checkOutput("idle gap busy", 32'(busyA[0]), 32'd0);
        tAcc = cyc;
        stbLog.delete();
        doneLog.delete();
        expQ.push_back('{inst: 2'd0, b: 8'h96});
        @(negedge clk);
        startA[0] = 1'b0;
        checkOutput("re-accept busy", 32'(busyA[0]), 32'd1);
        checkOutput("re-accept tx", 32'(txA[0]), 32'd0);
        waitDone(0, tAcc, 100, tDone);
        checkStrobes(tAcc, 1, 100);
        checkAfterDone(0);
        checkOutput("scoreboard drained re-accept", 32'(expQ.size()), 32'd0);

        // Two stop bits: one zero byte is 90 low cycles then 20 high.
        applyStimulus(2, 32'h00000000, 3'd1, 1, 1'b0, tAcc);
        bad = 0;
        for (int i = 1; i <= 110; i++) begin
            if (txA[2] !== (i > 90)) bad++;
            if (i < 110) @(negedge clk);
        end
        checkOutput("stop2 tx profile errors", 32'(bad), 32'd0);
        checkOutput("stop2 done at T+110", 32'(doneA[2]), 32'd1);
        checkOutput("stop2 busy low at done", 32'(busyA[2]), 32'd0);
        checkAfterDone(2);
        checkStrobes(tAcc, 1, 110);
        checkOutput("scoreboard drained stop2", 32'(expQ.size()), 32'd0);

        // Reset during bit 3 of byte 1 aborts the frame immediately.
        applyStimulus(0, 32'h87654321, 3'd0, 4, 1'b0, tAcc);
        while (cyc < tAcc + 145) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort tx high", 32'(txA[0]), 32'd1);
        checkOutput("abort busy low", 32'(busyA[0]), 32'd0);
        checkOutput("abort done low", 32'(doneA[0]), 32'd0);
        repeat (3) @(negedge clk);
        expQ.delete();
        rst_n = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (txA[0] !== 1'b1 || busyA[0] !== 1'b0) bad++;
        end
        checkOutput("stays idle after abort", 32'(bad), 32'd0);
        checkOutput("no done for aborted block", 32'(doneLog.size()), 32'd0);
        applyStimulus(0, 32'h87654321, 3'd0, 4, 1'b0, tAcc);
        waitDone(0, tAcc, 400, tDone);
        checkStrobes(tAcc, 4, 100);
        checkAfterDone(0);

        repeat (20) @(negedge clk);
        checkOutput("scoreboard empty at end", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
